// File: rtl/life_controller.sv
// Game of Life sequencer: cursor-based pattern editing, paced generation advances
// (freeze strobe), stability detection, generation counting and live-cell population.
module life_controller #(
  parameter int TICK_BASE = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_start,
  input  logic              btn_pause,
  input  logic              btn_step,
  input  logic              btn_clear,
  input  logic              cur_up,
  input  logic              cur_down,
  input  logic              cur_left,
  input  logic              cur_right,
  input  logic              cur_toggle,
  input  logic [1:0]        speed_sel,
  input  logic [15:0][15:0] cell_status,
  output logic [15:0][15:0] user_grid,
  output logic              game_state,
  output logic              freeze,
  output logic [3:0]        cursor_x,
  output logic [3:0]        cursor_y,
  output logic [1:0]        mode,
  output logic [15:0]       generation,
  output logic [8:0]        population,
  output logic              stable
);

  typedef enum logic [1:0] {EDIT = 2'd0, RUN = 2'd1, EVAL = 2'd2, PAUSE = 2'd3} state_t;

  state_t            state_q, state_d;
  logic              ret_pause_q;
  logic [31:0]       tick_q, period_q, period_sel;
  logic [15:0][15:0] snapshot_q;
  logic              cmd_clear, cmd_pause, cmd_start, cmd_step;
  logic              advance, restart, leave, unchanged;
  logic [3:0]        dx, dy;
  logic [8:0]        pop_c;

  // One command per cycle: clear > pause > start > step.
  assign cmd_clear = btn_clear;
  assign cmd_pause = btn_pause && !btn_clear;
  assign cmd_start = btn_start && !btn_clear && !btn_pause;
  assign cmd_step  = btn_step && !btn_clear && !btn_pause && !btn_start;

  assign period_sel = 32'(TICK_BASE) << (2'd3 - speed_sel);
  assign unchanged  = (cell_status == snapshot_q);
  assign leave      = cmd_clear && (state_q != EDIT);

  // The advance cycle is the only cycle outside EDIT where freeze drops, letting
  // the grid step exactly one generation on the following edge.
  always_comb begin
    advance = 1'b0;
    if (state_q == RUN)
      advance = !cmd_clear && !cmd_pause && (tick_q == period_q - 32'd1);
    else if (state_q == PAUSE)
      advance = cmd_step;
  end

  assign restart = advance || (((state_q == EDIT) || (state_q == PAUSE)) && cmd_start);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EDIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EDIT:  if (cmd_start) state_d = RUN;
      RUN: begin
        if (cmd_clear)      state_d = EDIT;
        else if (cmd_pause) state_d = PAUSE;
        else if (advance)   state_d = EVAL;
      end
      EVAL: begin
        if (cmd_clear)                     state_d = EDIT;
        else if (unchanged || ret_pause_q) state_d = PAUSE;
        else                               state_d = RUN;
      end
      PAUSE: begin
        if (cmd_clear)      state_d = EDIT;
        else if (cmd_start) state_d = RUN;
        else if (advance)   state_d = EVAL;
      end
      default: state_d = EDIT;
    endcase
  end

  always_comb begin
    mode       = state_q;
    game_state = (state_q != EDIT);
    freeze     = (state_q != EDIT) && !advance;
  end

  // The EVAL cycle is counted so consecutive advances in RUN are exactly P apart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q   <= '0;
      period_q <= '0;
    end else if (leave) begin
      tick_q <= '0;
    end else if (restart) begin
      tick_q   <= '0;
      period_q <= period_sel;
    end else if (((state_q == RUN) && !cmd_pause) || (state_q == EVAL)) begin
      tick_q <= tick_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      generation <= '0;
      stable     <= 1'b0;
    end else if (leave || ((state_q == EDIT) && cmd_start)) begin
      generation <= '0;
      stable     <= 1'b0;
    end else begin
      if (advance && (generation != 16'hFFFF)) generation <= generation + 16'd1;
      if (state_q == EVAL) stable <= unchanged;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snapshot_q  <= '0;
      ret_pause_q <= 1'b0;
    end else if (advance) begin
      snapshot_q  <= cell_status;
      ret_pause_q <= (state_q == PAUSE);
    end
  end

  always_comb begin
    dx = 4'd0;
    dy = 4'd0;
    if (cur_right && !cur_left)      dx = 4'd1;
    else if (cur_left && !cur_right) dx = 4'hF;
    if (cur_down && !cur_up)         dy = 4'd1;
    else if (cur_up && !cur_down)    dy = 4'hF;
  end

  // Toggle addresses the cursor as it was before any move in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      user_grid <= '0;
      cursor_x  <= '0;
      cursor_y  <= '0;
    end else if (state_q == EDIT) begin
      if (cmd_clear) begin
        user_grid <= '0;
      end else begin
        if (cur_toggle) user_grid[cursor_y][cursor_x] <= ~user_grid[cursor_y][cursor_x];
        cursor_x <= cursor_x + dx;
        cursor_y <= cursor_y + dy;
      end
    end
  end

  always_comb begin
    pop_c = '0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        pop_c = pop_c + {8'd0, cell_status[r][c]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) population <= '0;
    else        population <= pop_c;
  end

endmodule

// File: tb/tb_life_controller.sv
// Bench for life_controller: a Life grid plant driven by game_state/freeze, a
// high-level generation model feeding an expected-advance queue, and a monitor.
module tb_life_controller;
  localparam int TB = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              btn_start = 0, btn_pause = 0, btn_step = 0, btn_clear = 0;
  logic              cur_up = 0, cur_down = 0, cur_left = 0, cur_right = 0, cur_toggle = 0;
  logic [1:0]        speed_sel = 2'd3;
  logic [15:0][15:0] cell_status;
  logic [15:0][15:0] user_grid;
  logic              game_state, freeze, stable;
  logic [3:0]        cursor_x, cursor_y;
  logic [1:0]        mode;
  logic [15:0]       generation;
  logic [8:0]        population;

  life_controller #(.TICK_BASE(TB)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_start(btn_start), .btn_pause(btn_pause), .btn_step(btn_step), .btn_clear(btn_clear),
    .cur_up(cur_up), .cur_down(cur_down), .cur_left(cur_left), .cur_right(cur_right),
    .cur_toggle(cur_toggle), .speed_sel(speed_sel), .cell_status(cell_status),
    .user_grid(user_grid), .game_state(game_state), .freeze(freeze),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .mode(mode), .generation(generation),
    .population(population), .stable(stable)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference functions ----------------
  function automatic logic [15:0][15:0] life_step(input logic [15:0][15:0] g);
    logic [15:0][15:0] n;
    int cnt;
    n = '0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (!(dr == 0 && dc == 0) && r + dr >= 0 && r + dr < 16 && c + dc >= 0 && c + dc < 16)
              cnt += int'(g[r + dr][c + dc]);
        n[r][c] = (cnt == 3) || (g[r][c] && cnt == 2);
      end
    return n;
  endfunction

  function automatic int popcnt(input logic [15:0][15:0] g);
    int n;
    n = 0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        n += int'(g[r][c]);
    return n;
  endfunction

  // Grid plant: loads the user pattern in EDIT, steps one generation when unfrozen.
  always @(posedge clk or negedge rst_n)
    if (!rst_n)           cell_status <= '0;
    else if (!game_state) cell_status <= user_grid;
    else if (!freeze)     cell_status <= life_step(cell_status);

  // ---------------- scoreboard ----------------
  // entry = {advance cycle[31:0], generation[15:0], stable, mode after EVAL[1:0], population[8:0]}
  logic [59:0] exp_q[$];
  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  initial begin : monitor
    logic [59:0] got, exp;
    int acyc;
    forever begin
      @(negedge clk);
      if (rst_n && game_state === 1'b1 && freeze === 1'b0) begin
        acyc = cyc;
        @(negedge clk);
        @(negedge clk);
        got = {32'(acyc), generation, stable, mode, population};
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_advance: freeze dropped at cycle %0d, none expected", acyc);
        end else begin
          exp = exp_q.pop_front();
          if (got === exp) n_pass++;
          else $display("FAIL advance: got cyc=%0d gen=%0d stable=%0b mode=%0d pop=%0d expected cyc=%0d gen=%0d stable=%0b mode=%0d pop=%0d",
                        got[59:28], got[27:12], got[11], got[10:9], got[8:0],
                        exp[59:28], exp[27:12], exp[11], exp[10:9], exp[8:0]);
        end
      end
    end
  end

  // ---------------- high-level model state ----------------
  logic [15:0][15:0] ref_grid = '0;
  logic [15:0][15:0] m_cells = '0;
  int ref_x = 0, ref_y = 0;
  logic [15:0] m_gen = 0;

  // Predict up to n_max generations of a run starting at cycle s with period p.
  task automatic run_model(input int s, input int p, input int n_max);
    logic [15:0][15:0] nxt;
    logic st;
    for (int i = 1; i <= n_max; i++) begin
      nxt = life_step(m_cells);
      st = (nxt == m_cells);
      if (m_gen != 16'hFFFF) m_gen = m_gen + 16'd1;
      m_cells = nxt;
      exp_q.push_back({32'(s + i * p), m_gen, st, st ? 2'd3 : 2'd1, 9'(popcnt(nxt))});
      if (st) break;
    end
  endtask

  task automatic step_model(input int t);
    logic [15:0][15:0] nxt;
    logic st;
    nxt = life_step(m_cells);
    st = (nxt == m_cells);
    if (m_gen != 16'hFFFF) m_gen = m_gen + 16'd1;
    m_cells = nxt;
    exp_q.push_back({32'(t), m_gen, st, 2'd3, 9'(popcnt(nxt))});
  endtask

  // ---------------- driver tasks ----------------
  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step_clk();
  endtask

  task automatic press(input logic st, input logic pa, input logic sp, input logic cl, output int at);
    btn_start = st; btn_pause = pa; btn_step = sp; btn_clear = cl;
    at = cyc;
    step_clk();
    btn_start = 0; btn_pause = 0; btn_step = 0; btn_clear = 0;
  endtask

  task automatic drive_cursor(input logic u, input logic d, input logic l, input logic r, input logic t);
    cur_up = u; cur_down = d; cur_left = l; cur_right = r; cur_toggle = t;
    step_clk();
    cur_up = 0; cur_down = 0; cur_left = 0; cur_right = 0; cur_toggle = 0;
  endtask

  task automatic edit(input logic u, input logic d, input logic l, input logic r, input logic t);
    if (t) ref_grid[ref_y][ref_x] = ~ref_grid[ref_y][ref_x];
    if (r && !l) ref_x = (ref_x + 1) % 16;
    else if (l && !r) ref_x = (ref_x + 15) % 16;
    if (d && !u) ref_y = (ref_y + 1) % 16;
    else if (u && !d) ref_y = (ref_y + 15) % 16;
    drive_cursor(u, d, l, r, t);
  endtask

  task automatic place(input int r, input int c);
    while (ref_x != c) edit(0, 0, 0, 1, 0);
    while (ref_y != r) edit(0, 1, 0, 0, 0);
    edit(0, 0, 0, 0, 1);
  endtask

  task automatic wait_drain(input int budget, input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      step_clk();
      k++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL %s: %0d expected advances still pending after %0d cycles", name, exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mode"}, mode, 2'd0);
    chk({tag, "_grid"}, user_grid, '0);
    chk({tag, "_cursor"}, {cursor_y, cursor_x}, 8'd0);
    chk({tag, "_gen"}, generation, 16'd0);
    chk({tag, "_pop"}, population, 9'd0);
    chk({tag, "_stable"}, stable, 1'b0);
    chk({tag, "_gs_frz"}, {game_state, freeze}, 2'b00);
  endtask

  // ---------------- stimulus ----------------
  initial begin : stimulus
    logic [15:0][15:0] g;
    logic [4:0] b;
    int s, nops, per;
    logic [1:0] sp;

    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);

    // toggle, right x3, toggle
    edit(0, 0, 0, 0, 1);
    repeat (3) edit(0, 0, 0, 1, 0);
    edit(0, 0, 0, 0, 1);
    #2;
    g = '0; g[0][0] = 1'b1; g[0][3] = 1'b1;
    chk("edit_grid", user_grid, g);
    chk("edit_cursor", {cursor_y, cursor_x}, {4'd0, 4'd3});

    // wraparound and opposing moves
    repeat (3) edit(0, 0, 1, 0, 0);
    edit(0, 0, 1, 0, 0);
    edit(1, 0, 0, 0, 0);
    #2 chk("wrap_cursor", {cursor_y, cursor_x}, {4'd15, 4'd15});
    edit(0, 0, 1, 1, 0);
    edit(1, 1, 0, 0, 0);
    #2 chk("opposed_cursor", {cursor_y, cursor_x}, {4'd15, 4'd15});
    edit(0, 1, 0, 1, 0);
    #2 chk("down_right_wrap", {cursor_y, cursor_x}, {4'd0, 4'd0});

    press(0, 0, 0, 1, s);
    ref_grid = '0;
    #2;
    chk("edit_clear_grid", user_grid, '0);
    chk("edit_clear_cursor", {cursor_y, cursor_x}, {4'(ref_y), 4'(ref_x)});

    // vertical blinker, three advances in RUN
    place(4, 5); place(5, 5); place(6, 5);
    idle(2);
    #2;
    chk("blinker_grid", user_grid, ref_grid);
    chk("blinker_pop", population, 9'd3);
    m_cells = ref_grid; m_gen = 0;
    press(1, 0, 0, 0, s);
    #2 chk("run_entry", {mode, game_state, freeze}, {2'd1, 1'b1, 1'b1});
    run_model(s, 4, 3);
    wait_drain(40, "blinker_run");
    press(0, 1, 0, 0, s);
    #2 chk("pause_mode", mode, 2'd3);

    // cursor and toggle ignored outside EDIT
    drive_cursor(0, 0, 0, 1, 1);
    #2 chk("pause_cursor_ignored", {cursor_y, cursor_x, user_grid}, {4'(ref_y), 4'(ref_x), ref_grid});

    // single step, then start+pause together stays in PAUSE
    press(0, 0, 1, 0, s);
    step_model(s);
    wait_drain(10, "blinker_step");
    press(1, 1, 0, 0, s);
    idle(10);
    #2 chk("start_pause_same_cycle", {mode, generation}, {2'd3, m_gen});

    // resume, one advance, clear in RUN
    press(1, 0, 0, 0, s);
    run_model(s, 4, 1);
    wait_drain(20, "resume_run");
    press(0, 0, 0, 1, s);
    m_cells = ref_grid; m_gen = 0;
    #2 chk("clear_run", {mode, generation, stable, user_grid}, {2'd0, 16'd0, 1'b0, ref_grid});
    idle(2);
    #2 chk("reload_pop", population, 9'(popcnt(ref_grid)));
    press(0, 0, 0, 1, s);
    ref_grid = '0;
    #2 chk("second_clear", user_grid, '0);

    // 2x2 block still life stops on the first advance
    place(8, 8); place(8, 9); place(9, 8); place(9, 9);
    idle(2);
    m_cells = ref_grid; m_gen = 0;
    press(1, 0, 0, 0, s);
    run_model(s, 4, 5);
    wait_drain(40, "block_run");
    #2 chk("block_stable", {mode, stable, generation}, {2'd3, 1'b1, 16'd1});
    press(0, 0, 1, 0, s);
    step_model(s);
    wait_drain(10, "block_step");

    // slowest rate: P = 32
    press(0, 0, 0, 1, s);
    m_cells = ref_grid; m_gen = 0;
    speed_sel = 2'd0;
    idle(2);
    press(1, 0, 0, 0, s);
    run_model(s, 32, 1);
    wait_drain(60, "slow_run");
    speed_sel = 2'd3;
    press(0, 0, 0, 1, s);
    press(0, 0, 0, 1, s);
    ref_grid = '0; m_gen = 0;

    // randomized patterns and run lengths
    for (int it = 0; it < 4; it++) begin
      nops = $urandom_range(20, 40);
      for (int k = 0; k < nops; k++) begin
        b = 5'($urandom);
        edit(b[0], b[1], b[2], b[3], b[4]);
      end
      idle(2);
      #2;
      chk("rnd_grid", user_grid, ref_grid);
      chk("rnd_cursor", {cursor_y, cursor_x}, {4'(ref_y), 4'(ref_x)});
      chk("rnd_pop", population, 9'(popcnt(ref_grid)));
      sp = 2'($urandom_range(2, 3));
      speed_sel = sp;
      per = TB << (3 - int'(sp));
      m_cells = ref_grid; m_gen = 0;
      press(1, 0, 0, 0, s);
      run_model(s, per, $urandom_range(1, 3));
      wait_drain(200, "rnd_run");
      press(0, 1, 0, 0, s);
      #2 chk("rnd_pause", {mode, generation}, {2'd3, m_gen});
      press(0, 0, 1, 0, s);
      step_model(s);
      wait_drain(20, "rnd_step");
      press(0, 0, 0, 1, s);
      m_gen = 0;
      #2 chk("rnd_clear", {mode, generation, user_grid}, {2'd0, 16'd0, ref_grid});
      if ($urandom_range(0, 1) == 1) begin
        press(0, 0, 0, 1, s);
        ref_grid = '0;
        #2 chk("rnd_clear2", user_grid, '0);
      end
    end

    // asynchronous reset in the middle of RUN
    speed_sel = 2'd3;
    press(0, 0, 0, 1, s);
    ref_grid = '0;
    place(2, 2); place(3, 2); place(4, 2);
    idle(2);
    m_cells = ref_grid; m_gen = 0;
    press(1, 0, 0, 0, s);
    run_model(s, 4, 1);
    wait_drain(20, "pre_reset_run");
    rst_n = 1'b0;
    #2 check_reset_outputs("midrun_reset");
    step_clk();
    rst_n = 1'b1;
    ref_grid = '0; ref_x = 0; ref_y = 0; m_gen = 0;
    idle(16);
    #2 chk("post_reset_idle", {mode, generation, game_state}, {2'd0, 16'd0, 1'b0});

    idle(3);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/life_controller.md
LIFE_CONTROLLER -- requirements
Module: life_controller

Interface
REQ-001 Parameter TICK_BASE, default 1000000, sets the base generation period in clk cycles.
REQ-002 clk  in  1  system clock, all state changes on rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 btn_start, btn_pause, btn_step, btn_clear  in  1 each  single-cycle synchronized command pulses.
REQ-005 cur_up, cur_down, cur_left, cur_right, cur_toggle  in  1 each  single-cycle edit-cursor pulses.
REQ-006 speed_sel  in  2  generation rate select; 3 is fastest.
REQ-007 cell_status  in  [15:0][15:0]  current grid state, indexed [row][col].
REQ-008 user_grid  out  [15:0][15:0]  edited pattern driven to the grid's userInput.
REQ-009 game_state  out  1  0 = grid loads user_grid, 1 = grid evolves.
REQ-010 freeze  out  1  1 = grid holds, 0 = grid advances one generation this cycle.
REQ-011 cursor_x, cursor_y  out  4 each  edit cursor column/row.
REQ-012 mode  out  2  0 EDIT, 1 RUN, 2 EVAL, 3 PAUSE.
REQ-013 generation  out  16  generations since leaving EDIT.
REQ-014 population  out  9  registered live-cell count of cell_status, 0..256.
REQ-015 stable  out  1  last advance produced an unchanged grid.

Function
REQ-016 EDIT: game_state=0, freeze=0; cur_* pulses move the cursor with mod-16 wrap (left at x=0 -> 15, up at y=0 -> 15, down at y=15 -> 0).
REQ-017 Opposing moves in the same cycle (up+down, left+right) leave that axis unchanged.
REQ-018 cur_toggle inverts user_grid[cursor_y][cursor_x] at the pre-move cursor position when it coincides with a move.
REQ-019 btn_clear in EDIT zeroes user_grid; cursor is unchanged.
REQ-020 btn_start in EDIT -> RUN; tick counter = 0, generation = 0, stable = 0.
REQ-021 RUN, PAUSE and EVAL drive game_state=1; freeze=1 except on advance cycles.
REQ-022 Period P = TICK_BASE << (3 - speed_sel), sampled when the tick counter restarts.
REQ-023 RUN: tick counter increments each cycle; at count P-1, freeze=0 for exactly one cycle (the advance), counter restarts, cell_status captured into snapshot, generation increments (saturating at 16'hFFFF), next state EVAL.
REQ-024 EVAL (one cycle): if cell_status == snapshot then stable=1 and next state PAUSE; else stable=0 and return to the state that issued the advance.
REQ-025 PAUSE: btn_step issues one advance (REQ-023 actions, then EVAL returning to PAUSE); btn_start -> RUN with tick counter = 0.
REQ-026 Command priority in one cycle: btn_clear > btn_pause > btn_start > btn_step; lower-priority commands are dropped.
REQ-027 btn_pause in RUN -> PAUSE; tick counter holds.
REQ-028 btn_clear in RUN/PAUSE/EVAL -> EDIT; generation=0, stable=0, user_grid retained, cells reload it.
REQ-029 Commands arriving during EVAL are dropped, except btn_clear.
REQ-030 Cursor and toggle pulses are ignored outside EDIT.
REQ-031 population = popcount(cell_status) registered every cycle, one-cycle latency, in all modes.

Reset
REQ-032 rst_n low asynchronously forces: mode=EDIT, user_grid=0, cursor_x=cursor_y=0, generation=0, population=0, stable=0, game_state=0, freeze=0, tick counter=0, snapshot=0.
REQ-033 Reset asserted mid-RUN or mid-EVAL aborts any pending advance; no freeze=0 pulse occurs after release until a new advance is issued.

Verification (TICK_BASE=4, speed_sel=3 so P=4 unless noted)
REQ-034 Reset; toggle; right x3; toggle -> user_grid[0][0]=1, user_grid[0][3]=1, cursor_x=3, cursor_y=0.
REQ-035 Cursor at (0,0); left; up; left+right same cycle -> cursor_x=15, cursor_y=15, then unchanged.
REQ-036 Vertical blinker at rows 4..6 col 5; start -> freeze=0 exactly on the 4th cycle after start; generation=1; EVAL -> RUN; stable=0; population stays 3.
REQ-037 2x2 block still life; start -> after the first advance, EVAL sets stable=1, mode=PAUSE, generation=1.
REQ-038 PAUSE; btn_step -> one freeze=0 cycle, generation +1; btn_start+btn_pause same cycle -> stays PAUSE.
REQ-039 btn_clear in RUN -> mode=EDIT, generation=0, user_grid unchanged; second btn_clear -> user_grid=0; speed_sel=0 -> advance period 32 cycles.
